uart_axi_master: RTL and testbench

// - UART-to-AXI-Lite initiator for host debug/boot loading: decodes command frames from the serial line, issues single AXI-Lite reads/writes as bus master, returns replies over UART.
// - Sits on the interconnect master side, opposite the UART peripheral (responder); instantiates uart_rx/uart_tx (data/data_valid/data_ready streams).

---
 rtl/uart_axi_master.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_axi_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_master.sv
//==============================================================================
// uart_axi_master : UART command frames -> single AXI-Lite reads/writes.
// Option macro: UART_AXI_MASTER_TIMEOUT_EN (inter-byte timeout). Rev 1.0
//==============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);

  logic [1:0]    sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      busy       <= 1'b0;
      cnt        <= '0;
      bitn       <= 4'd0;
      shreg      <= 8'h00;
      data       <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (!busy) begin
        if (!sync[1]) begin
          busy <= 1'b1;
          cnt  <= CW'(DIV / 2);
          bitn <= 4'd0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt  <= CW'(DIV - 1);
        bitn <= bitn + 4'd1;
        // A new byte overwrites an unread one; overrun is not flagged.
        if (bitn == 4'd0 && sync[1]) begin
          busy <= 1'b0;
        end else if (bitn == 4'd9) begin
          busy       <= 1'b0;
          data       <= shreg;
          data_valid <= 1'b1;
        end else if (bitn != 4'd0) begin
          shreg <= {sync[1], shreg[7:1]};
        end
      end
    end
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);

  logic [9:0]    shreg;
  logic [3:0]    left;
  logic [CW-1:0] cnt;

  assign data_ready = (left == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '1;
      left  <= 4'd0;
      cnt   <= '0;
      tx    <= 1'b1;
    end else begin
      tx <= (left != 4'd0) ? shreg[0] : 1'b1;
      if (left == 4'd0) begin
        if (data_valid) begin
          shreg <= {1'b1, data, 1'b0};
          left  <= 4'd10;
          cnt   <= CW'(DIV - 1);
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        shreg <= {1'b1, shreg[9:1]};
        left  <= left - 4'd1;
        cnt   <= CW'(DIV - 1);
      end
    end
  end
endmodule

module uart_axi_master #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD_RATE      = 115200,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  tx,
  input  logic                  rx
);
  localparam int AB = ADDR_WIDTH / 8;
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15, BAD = 8'h3F, TMO = 8'h54;

  if (ADDR_WIDTH != 8 && ADDR_WIDTH != 16 && ADDR_WIDTH != 24 && ADDR_WIDTH != 32) begin : g_bad_addr_width
    $error("uart_axi_master: ADDR_WIDTH must be 8, 16, 24 or 32");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_REPLY
  } state_t;
  state_t state, state_n;

  logic [7:0]            rx_byte;
  logic                  rx_valid, rx_ready, tx_ready, tmo, is_wr;
  logic [2:0]            cnt, rlen;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [39:0]           rbuf;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .data(rx_byte), .data_valid(rx_valid), .data_ready(rx_ready));
  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk), .rst(rst), .data(rbuf[7:0]), .data_valid(state == S_REPLY), .data_ready(tx_ready), .tx(tx));

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign awprot = 3'b000;
  assign arprot = 3'b000;

`ifdef UART_AXI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk) begin
    if (rst || !(state == S_ADDR || state == S_DATA) || rx_valid) tcnt <= '0;
    else                                                          tcnt <= tcnt + TW'(1);
  end
  assign tmo = (state == S_ADDR || state == S_DATA) && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = (rx_byte == OP_W || rx_byte == OP_R) ? S_ADDR : S_REPLY;
      end
      S_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid && cnt == 3'(AB - 1)) state_n = is_wr ? S_DATA : S_RD_REQ;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && cnt == 3'd3) state_n = S_WR_REQ;
      end
      // Each channel is done once its valid has dropped or it handshakes now.
      S_WR_REQ:  if ((!awvalid || awready) && (!wvalid || wready)) state_n = S_WR_RESP;
      S_WR_RESP: if (bvalid) state_n = S_REPLY;
      S_RD_REQ:  if (arready) state_n = S_RD_RESP;
      S_RD_RESP: if (rvalid) state_n = S_REPLY;
      S_REPLY:   if (tx_ready && rlen == 3'd1) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (tmo) state_n = S_REPLY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      is_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb   <= 4'h0;
      rbuf    <= 40'h0;
      rlen    <= 3'd0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 3'd0 : cnt + {2'b00, rx_valid & rx_ready};
      case (state)
        S_IDLE: if (rx_valid) begin
          is_wr <= (rx_byte == OP_W);
          rbuf  <= {32'h0, BAD};
          rlen  <= 3'd1;
        end
        S_ADDR: if (rx_valid) begin
          addr_q <= ADDR_WIDTH'({rx_byte, addr_q} >> 8);
          if (state_n == S_RD_REQ) arvalid <= 1'b1;
        end
        S_DATA: if (rx_valid) begin
          wdata_q <= {rx_byte, wdata_q[31:8]};
          if (state_n == S_WR_REQ) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            wstrb   <= 4'hF;
          end
        end
        S_WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready) begin
            wvalid <= 1'b0;
            wstrb  <= 4'h0;
          end
          if (state_n == S_WR_RESP) bready <= 1'b1;
        end
        S_WR_RESP: if (bvalid) begin
          bready <= 1'b0;
          rbuf   <= {32'h0, (bresp == 2'b00) ? ACK : NAK};
          rlen   <= 3'd1;
        end
        S_RD_REQ: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        S_RD_RESP: if (rvalid) begin
          rready <= 1'b0;
          rbuf   <= {(rresp == 2'b00) ? ACK : NAK, rdata};
          rlen   <= 3'd5;
        end
        S_REPLY: if (tx_ready) begin
          rbuf <= rbuf >> 8;
          rlen <= rlen - 3'd1;
        end
        default: ;
      endcase
      if (tmo) begin
        rbuf <= {32'h0, TMO};
        rlen <= 3'd1;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_axi_master.sv
//==============================================================================
// tb_uart_axi_master : scoreboard bench driving UART frames into an AXI-Lite slave model.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_uart_axi_master;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, tx, rx;
  logic [1:0]  bresp, rresp;

  uart_axi_master #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tx(tx), .rx(rx));

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [8:0]  exp_q[$];
  int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, valid_cycles = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0, cfg_rdata = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [2:0]  cap_awprot = 0, cap_arprot = 0;
  logic [1:0]  cfg_bresp = 0, cfg_rresp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // AXI-Lite slave: ready/valid decided on the falling edge for the next rising edge.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (awvalid === 1'b1 || wvalid === 1'b1 || arvalid === 1'b1) valid_cycles++;
      if (awvalid === 1'b1) begin aw_wait++; awready = (aw_wait > aw_delay); end
      else begin aw_wait = 0; awready = 0; end
      if (awvalid === 1'b1 && awready) begin aw_hs++; cap_awaddr = awaddr; cap_awprot = awprot; end
      if (wvalid === 1'b1) begin w_wait++; wready = (w_wait > w_delay); end
      else begin w_wait = 0; wready = 0; end
      if (wvalid === 1'b1 && wready) begin w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
      arready = (arvalid === 1'b1);
      if (arready) begin ar_hs++; cap_araddr = araddr; cap_arprot = arprot; end
      bvalid = (bready === 1'b1); bresp = cfg_bresp;
      rvalid = (rready === 1'b1); rdata = cfg_rdata; rresp = cfg_rresp;
    end
  end

  // Serial receiver on tx: each completed byte is popped against the scoreboard.
  initial begin
    logic [7:0] b;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
        repeat (BIT + BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          if (i < 7) repeat (BIT) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
        check_eq("tx_byte", {24'h0, b}, {23'h0, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic push_read_reply(input logic [31:0] d, input logic [7:0] last);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, d[8*i +: 8]});
    exp_q.push_back({1'b0, last});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(posedge clk); n++; end
    repeat (3 * BIT) @(posedge clk);
    #1;
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic pulse_rst(input string tag);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_valids"}, {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
    check_eq({tag, "_tx"}, {31'h0, tx}, 32'h1);
    rst = 1'b0;
  endtask

  initial begin
    int a0, w0, r0, v0, n;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
    check_eq("rst_tx", {31'h0, tx}, 32'h1);
    check_eq("rst_awaddr", awaddr, 32'h0);
    check_eq("rst_wdata", wdata, 32'h0);
    check_eq("rst_wstrb", {28'h0, wstrb}, 32'h0);
    rst = 1'b0;

    a0 = aw_hs; w0 = w_hs;
    exp_q.push_back(9'h006);
    send_write(32'h0000_1000, 32'hDEAD_BEEF);
    wait_drain("wr1");
    check_eq("wr1_awaddr", cap_awaddr, 32'h0000_1000);
    check_eq("wr1_wdata", cap_wdata, 32'hDEAD_BEEF);
    check_eq("wr1_wstrb", {28'h0, cap_wstrb}, 32'hF);
    check_eq("wr1_awprot", {29'h0, cap_awprot}, 32'h0);
    check_eq("wr1_aw_hs", aw_hs - a0, 1);
    check_eq("wr1_w_hs", w_hs - w0, 1);

    r0 = ar_hs;
    cfg_rdata = 32'h0000_0003; cfg_rresp = 2'b00;
    push_read_reply(32'h0000_0003, 8'h06);
    send_read(32'h0000_0004);
    wait_drain("rd1");
    check_eq("rd1_araddr", cap_araddr, 32'h4);
    check_eq("rd1_arprot", {29'h0, cap_arprot}, 32'h0);
    check_eq("rd1_ar_hs", ar_hs - r0, 1);

    cfg_bresp = 2'b10;
    exp_q.push_back(9'h015);
    send_write(32'h2000_0010, 32'h1234_5678);
    wait_drain("wr_slverr");
    cfg_bresp = 2'b00;

    cfg_rdata = 32'hA5C3_1E77; cfg_rresp = 2'b11;
    push_read_reply(32'hA5C3_1E77, 8'h15);
    send_read(32'h0000_0100);
    wait_drain("rd_decerr");
    cfg_rresp = 2'b00;

    v0 = valid_cycles;
    exp_q.push_back(9'h03F);
    send_byte(8'h41);
    wait_drain("badop");
    check_eq("badop_no_valid", valid_cycles - v0, 0);
    cfg_rdata = 32'h0102_0304;
    push_read_reply(32'h0102_0304, 8'h06);
    send_read(32'h0000_0008);
    wait_drain("after_badop");
    check_eq("after_badop_araddr", cap_araddr, 32'h8);

    a0 = aw_hs; w0 = w_hs;
    aw_delay = 0; w_delay = 3;
    exp_q.push_back(9'h006);
    send_write(32'h1234_5678, 32'h0BAD_F00D);
    wait_drain("aw_first");
    check_eq("aw_first_aw_hs", aw_hs - a0, 1);
    check_eq("aw_first_w_hs", w_hs - w0, 1);
    check_eq("aw_first_awaddr", cap_awaddr, 32'h1234_5678);
    check_eq("aw_first_wdata", cap_wdata, 32'h0BAD_F00D);
    a0 = aw_hs; w0 = w_hs;
    aw_delay = 1; w_delay = 1;
    exp_q.push_back(9'h006);
    send_write(32'h0000_00C0, 32'hCAFE_0001);
    wait_drain("same_cyc");
    check_eq("same_cyc_aw_hs", aw_hs - a0, 1);
    check_eq("same_cyc_w_hs", w_hs - w0, 1);
    aw_delay = 0; w_delay = 0;

    send_byte(8'h57);
    send_byte(8'h01);
    pulse_rst("rst_addr");
    exp_q.push_back(9'h006);
    send_write(32'h0000_0040, 32'h5555_AAAA);
    wait_drain("post_rst_addr");
    check_eq("post_rst_addr_awaddr", cap_awaddr, 32'h0000_0040);
    check_eq("post_rst_addr_wdata", cap_wdata, 32'h5555_AAAA);

    aw_delay = 100000; w_delay = 100000;
    send_write(32'h0000_0080, 32'h7777_7777);
    n = 0;
    while (awvalid !== 1'b1 && n < 500) begin @(posedge clk); n++; end
    #1;
    check_eq("wrq_awvalid", {31'h0, awvalid}, 32'h1);
    pulse_rst("rst_wrq");
    aw_delay = 0; w_delay = 0;
    cfg_rdata = 32'h8765_4321;
    push_read_reply(32'h8765_4321, 8'h06);
    send_read(32'h0000_0020);
    wait_drain("post_rst_wrq");
    check_eq("post_rst_wrq_araddr", cap_araddr, 32'h20);

`ifdef UART_AXI_MASTER_TIMEOUT_EN
    a0 = aw_hs;
    exp_q.push_back(9'h054);
    send_byte(8'h57);
    send_byte(8'h00);
    wait_drain("timeout");
    check_eq("timeout_no_aw", aw_hs - a0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
